// File: rtl/image_generator_pkg.sv
// Shared definitions for the image_generator slice: pipe bundle layout,
// image-spec helpers, pattern encodings and the generator state type.
package image_generator_pkg;

    // In this slice an image spec carries the pixel data width directly.
    localparam int IS_DEFAULT = 8;

    // Pipe bundle bit layout, LSB first. Data occupies the top bits.
    localparam int PIPE_VALID   = 0;
    localparam int PIPE_START   = 1;
    localparam int PIPE_STOP    = 2;
    localparam int PIPE_ERROR   = 3;
    localparam int PIPE_READY   = 4;
    localparam int PIPE_REQUEST = 5;
    localparam int PIPE_CANCEL  = 6;
    localparam int PIPE_DATA    = 7;

    // Pattern select encodings.
    localparam logic [1:0] IG_PATTERN_CONST = 2'd0;
    localparam logic [1:0] IG_PATTERN_XRAMP = 2'd1;
    localparam logic [1:0] IG_PATTERN_YRAMP = 2'd2;
    localparam logic [1:0] IG_PATTERN_XOR   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ig_state_e;

    function automatic int i_data_w(input int is);
        return is;
    endfunction

    function automatic int i_w(input int is);
        return is + PIPE_DATA;
    endfunction

    // Counter width for n positions; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/image_pattern.sv
// Combinational test-pattern function: (pattern, x, y) -> pixel data.
// With IMAGE_GENERATOR_FRAME_COUNT_EN the XOR pattern is offset by the
// low byte of the frame counter so successive frames differ.
module image_pattern
    import image_generator_pkg::*;
#(
    parameter int DataW = 8,
    parameter int XW    = 4,
    parameter int YW    = 3
) (
    input  logic [1:0]       pattern,
    input  logic [XW-1:0]    x,
    input  logic [YW-1:0]    y,
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
    input  logic [7:0]       frame_low,
`endif
    output logic [DataW-1:0] data
);

    logic [31:0] x_ext;
    logic [31:0] y_ext;
    logic [31:0] value;

    assign x_ext = 32'(x);
    assign y_ext = 32'(y);

    // Evaluate the selected pattern at full width, then fit it to the pipe.
    always_comb begin
        value = '0;
        case (pattern)
            IG_PATTERN_CONST: value = 32'h55;
            IG_PATTERN_XRAMP: value = x_ext;
            IG_PATTERN_YRAMP: value = y_ext;
            IG_PATTERN_XOR: begin
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
                value = (x_ext ^ y_ext) + {24'd0, frame_low};
`else
                value = x_ext ^ y_ext;
`endif
            end
            default: value = '0;
        endcase
    end

    assign data = DataW'(value);

endmodule

// File: rtl/image_generator.sv
// Image pipe source: emits one synthetic Width x Height frame per request.
// Optional macro IMAGE_GENERATOR_FRAME_COUNT_EN adds a frame_count output
// and makes the XOR pattern move from frame to frame.
//
// Handshake: a pixel transfers on a clock edge where valid=1 and ready=1.
// While valid=1 and ready=0 the presented pixel (data/start/stop) is held.
// cancel=1 at an edge in Run discards the presented pixel and ends the
// frame; in Idle it blocks request. The current FSM state is visible as
// the signal state_q.
module image_generator
    import image_generator_pkg::*;
#(
    parameter int OutIS  = IS_DEFAULT,
    parameter int Width  = 16,
    parameter int Height = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              pattern,
    output logic                    busy,
    inout  wire  [i_w(OutIS)-1:0]   image_out
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
    ,
    output logic [15:0]             frame_count
`endif
);

    localparam int DataW = i_data_w(OutIS);
    localparam int XW    = cnt_w(Width);
    localparam int YW    = cnt_w(Height);
    localparam logic [XW-1:0] X_LAST = XW'(Width - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Height - 1);

    ig_state_e        state_q, state_n;
    logic [XW-1:0]    x_q, x_n;
    logic [YW-1:0]    y_q, y_n;
    logic [1:0]       pat_q, pat_n;
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
    logic [15:0]      fc_q, fc_n;
`endif

    logic             pipe_ready;
    logic             pipe_request;
    logic             pipe_cancel;
    logic             valid;
    logic             last_pixel;
    logic [DataW-1:0] pixel;

    assign pipe_ready   = image_out[PIPE_READY];
    assign pipe_request = image_out[PIPE_REQUEST];
    assign pipe_cancel  = image_out[PIPE_CANCEL];

    assign valid      = (state_q == ST_RUN);
    assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

    image_pattern #(
        .DataW (DataW),
        .XW    (XW),
        .YW    (YW)
    ) u_pattern (
        .pattern   (pat_q),
        .x         (x_q),
        .y         (y_q),
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
        .frame_low (fc_q[7:0]),
`endif
        .data      (pixel)
    );

    // Forward fields derive from registered state only, so an async reset
    // clears them at once. Data is forced to zero when nothing is presented.
    assign image_out[PIPE_VALID]        = valid;
    assign image_out[PIPE_START]        = valid && (x_q == '0) && (y_q == '0);
    assign image_out[PIPE_STOP]         = valid && last_pixel;
    assign image_out[PIPE_ERROR]        = 1'b0;
    assign image_out[PIPE_DATA +: DataW] = valid ? pixel : '0;
    assign busy                          = valid;
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
    assign frame_count                   = fc_q;
`endif

    // State, position, latched pattern and frame counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            pat_q   <= IG_PATTERN_CONST;
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
            fc_q    <= '0;
`endif
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            pat_q   <= pat_n;
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
            fc_q    <= fc_n;
`endif
        end
    end

    // Next-state logic: frame start, pixel advance, wrap, back-to-back and cancel.
    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        pat_n   = pat_q;
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
        fc_n    = fc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pipe_request && !pipe_cancel) begin
                    state_n = ST_RUN;
                    x_n     = '0;
                    y_n     = '0;
                    pat_n   = pattern;
                end
            end
            ST_RUN: begin
                if (pipe_cancel) begin
                    state_n = ST_IDLE;
                    x_n     = '0;
                    y_n     = '0;
                end else if (pipe_ready) begin
                    if (last_pixel) begin
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
                        fc_n = fc_q + 16'd1;
`endif
                        x_n = '0;
                        y_n = '0;
                        if (pipe_request) begin
                            pat_n = pattern;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else if (x_q == X_LAST) begin
                        x_n = '0;
                        y_n = y_q + 1'b1;
                    end else begin
                        x_n = x_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                x_n     = '0;
                y_n     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_image_generator.sv
// Scoreboard bench for image_generator (Width=4, Height=3, 8-bit data).
// Honours IMAGE_GENERATOR_FRAME_COUNT_EN when the design is built with it.
module tb_image_generator;
    import image_generator_pkg::*;

    localparam int IS = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int D  = i_data_w(IS);
    localparam int IW = i_w(IS);
    localparam int EW = D + 2;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic [1:0]    pattern = 2'd0;
    logic          ready   = 1'b1;
    logic          request = 1'b0;
    logic          cancel  = 1'b0;
    logic          busy;
    wire  [IW-1:0] pipe;
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
    logic [15:0]   frame_count;
`endif

    logic          pv, pstart, pstop, perr;
    logic [D-1:0]  pdata;

    assign pipe[PIPE_READY]   = ready;
    assign pipe[PIPE_REQUEST] = request;
    assign pipe[PIPE_CANCEL]  = cancel;
    assign pv     = pipe[PIPE_VALID];
    assign pstart = pipe[PIPE_START];
    assign pstop  = pipe[PIPE_STOP];
    assign perr   = pipe[PIPE_ERROR];
    assign pdata  = pipe[PIPE_DATA +: D];

    image_generator #(
        .OutIS  (IS),
        .Width  (W),
        .Height (H)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pattern     (pattern),
        .busy        (busy),
        .image_out   (pipe)
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
        ,
        .frame_count (frame_count)
`endif
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int             checks   = 0;
    int             failures = 0;
    logic [EW-1:0]  exp_q[$];
    int             model_fc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference pattern straight from the pattern definitions.
    function automatic logic [D-1:0] ref_pixel(input int p, input int x, input int y, input int fc);
        int v;
        case (p)
            0:       v = 'h55;
            1:       v = x;
            2:       v = y;
            default: begin
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
                v = (x ^ y) + (fc % 256);
`else
                v = x ^ y;
`endif
            end
        endcase
        return D'(v);
    endfunction

    // Queue the first npix pixels of a frame in raster order.
    task automatic push_frame(input int p, input int npix);
        logic [EW-1:0] e;
        int x, y;
        for (int i = 0; i < npix; i++) begin
            x = i % W;
            y = i / W;
            e = {(i == 0), (i == W * H - 1), ref_pixel(p, x, y, model_fc)};
            exp_q.push_back(e);
        end
        if (npix == W * H) model_fc = (model_fc + 1) % 65536;
    endtask

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_pix   = '0;

    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        forever begin
            @(negedge clock);
            got = {pstart, pstop, pdata};
            if (!reset) begin
                check("error_low", 32'(perr), 32'd0);
                if (prev_stall && pv) check("stall_hold", 32'(got), 32'(prev_pix));
                if (pv && ready && !cancel) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pixel actual=0x%0h required=none", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", 32'(got), 32'(e));
                    end
                end
                prev_stall = pv && !ready && !cancel;
                prev_pix   = got;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One-cycle request; the frame must appear one edge later.
    task automatic pulse(input logic [1:0] p);
        request = 1'b1;
        pattern = p;
        step();
        request = 1'b0;
        check("latency_valid", 32'(pv), 32'd1);
        check("latency_busy", 32'(busy), 32'd1);
        check("latency_start", 32'(pstart), 32'd1);
    endtask

    // Run until the frame drains. mode 0: ready=1, 1: 1 on/3 off, 2: random.
    task automatic wait_idle(input int mode);
        for (int c = 0; c < 2000; c++) begin
            if (!busy && exp_q.size() == 0) break;
            case (mode)
                1:       ready = (c % 4 == 0);
                2:       ready = 1'($urandom_range(0, 1));
                default: ready = 1'b1;
            endcase
            step();
        end
        ready = 1'b1;
        check("idle_reached", {30'd0, busy, (exp_q.size() != 0)}, 32'd0);
        check("idle_valid", 32'(pv), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        #3;
        check("reset_valid", 32'(pv), 32'd0);
        check("reset_start", 32'(pstart), 32'd0);
        check("reset_stop", 32'(pstop), 32'd0);
        check("reset_data", 32'(pdata), 32'd0);
        check("reset_error", 32'(perr), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
        check("reset_frame_count", 32'(frame_count), 32'd0);
`endif
        #19 reset = 1'b0;
        step();

        // Single frame, x ramp, ready always high.
        push_frame(1, W * H);
        pulse(2'd1);
        wait_idle(0);

        // Request held: two frames back-to-back with no valid gap.
        push_frame(3, W * H);
        push_frame(3, W * H);
        request = 1'b1;
        pattern = 2'd3;
        step();
        gap = 0;
        for (int i = 0; i < 2 * W * H; i++) begin
            if (pv !== 1'b1) gap++;
            if (i == W * H) request = 1'b0;
            step();
        end
        check("b2b_gap", 32'(gap), 32'd0);
        check("b2b_end_valid", 32'(pv), 32'd0);
        check("b2b_end_busy", 32'(busy), 32'd0);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Ready 1 on / 3 off, y ramp.
        push_frame(2, W * H);
        pulse(2'd2);
        wait_idle(1);

        // Cancel after pixel 5 accepted.
        push_frame(1, 6);
        request = 1'b1;
        pattern = 2'd1;
        step();
        request = 1'b0;
        repeat (6) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel_valid", 32'(pv), 32'd0);
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_drained", 32'(exp_q.size()), 32'd0);
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
        check("cancel_frame_count", 32'(frame_count), 32'(model_fc));
`endif
        push_frame(1, W * H);
        pulse(2'd1);
        wait_idle(0);

        // Asynchronous reset mid-frame after two pixels transferred.
        push_frame(2, 2);
        pulse(2'd2);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("areset_valid", 32'(pv), 32'd0);
        check("areset_start", 32'(pstart), 32'd0);
        check("areset_stop", 32'(pstop), 32'd0);
        check("areset_data", 32'(pdata), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        model_fc = 0;
        step();
        step();
        reset = 1'b0;
        step();
        push_frame(2, W * H);
        pulse(2'd2);
        wait_idle(0);

        // Request and cancel together in Idle: nothing starts.
        request = 1'b1;
        cancel  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("blocked_busy", 32'(busy), 32'd0);
            check("blocked_valid", 32'(pv), 32'd0);
        end
        request = 1'b0;
        cancel  = 1'b0;
        step();

        // Random patterns with random backpressure.
        for (int f = 0; f < 3; f++) begin
            logic [1:0] p;
            p = 2'($urandom_range(0, 3));
            push_frame(int'(p), W * H);
            pulse(p);
            wait_idle(2);
        end
`ifdef IMAGE_GENERATOR_FRAME_COUNT_EN
        check("final_frame_count", 32'(frame_count), 32'(model_fc));
`endif

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/image_generator.md
Name: image_generator

Overview:
- Source end of the image pipe protocol: produces a complete synthetic test-pattern frame when the downstream consumer raises request.
- Drives start/stop/data/valid/error forward; obeys ready/request/cancel coming back.
- Sits at the head of an image pipeline, e.g. feeding image_fifo, as a bring-up and verification source.

Parameters:
- OutIS, `IS_DEFAULT, image spec of the output pipe; data width is `I_Data_w(OutIS).
- Width, 16, pixels per line (>=2).
- Height, 8, lines per frame (>=1).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- pattern  input  2  pattern select: 0 constant 0x55, 1 x ramp, 2 y ramp, 3 x XOR y.
- busy  output  1  high while a frame is in progress.
- image_out  inout  `I_w(OutIS)  image pipe bundle. Forward fields are driven by this block: start, stop, data, valid, error. Back fields are read by this block: ready, request, cancel.

Behaviour:
- Reset (async, active-high): valid=0, start=0, stop=0, data=0, error=0, busy=0; x=0, y=0; state Idle.
- States: Idle, Run.
- Idle -> Run: on the clock edge where request=1 and cancel=0.
  - pattern is latched at this edge and held for the whole frame.
  - valid, busy and start rise on that edge with pixel (0,0): one cycle latency from request.
- Run, transfer rule: a pixel transfers at an edge with valid=1 and ready=1, then x advances.
  - x wraps from Width-1 to 0 and increments y.
- Run, stall rule: while valid=1 and ready=0, data/start/stop are held stable.
- Flags:
  - start=1 only on pixel (0,0).
  - stop=1 only on pixel (Width-1, Height-1).
  - Width=1 is not supported; Height=1 is allowed (start and stop both fall on line 0).
- Last pixel accepted:
  - If request=1 at that edge: next frame starts back-to-back, valid stays 1, start=1 on the new (0,0), pattern is re-latched.
  - Otherwise: go to Idle, valid=0, busy=0.
- Cancel=1 at any edge in Run:
  - Has priority over the transfer rule; the presented pixel is discarded.
  - Next state Idle, valid=0, x=y=0.
  - In Idle, cancel=1 blocks request.
- Request falling mid-frame has no effect; the frame always completes unless cancelled.
- Data value: computed from (x,y) per the latched pattern, zero-extended or truncated to the data width.
  - x and y counters are $clog2(Width) and $clog2(Height) bits, minimum 1.
- error: constant 0 (see Optional Feature).
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronously); no partial stop is emitted.

Optional Feature:
- Macro: IMAGE_GENERATOR_FRAME_COUNT_EN.
- With the macro:
  - Extra output port frame_count, 16 bits, reset 0.
  - frame_count increments on each accepted stop pixel and wraps at 0xFFFF.
  - Pattern 3 becomes (x XOR y) + frame_count[7:0], giving a moving pattern.
  - A cancelled frame does not increment frame_count.
- Without the macro: no frame_count port; pattern 3 is plain x XOR y.

Decomposition:
- Shared (image_defs.v): pattern encoding constants (IG_PATTERN_CONST/XRAMP/YRAMP/XOR); pipe field macros are already present there.
- Natural sub-module: image_pattern.
  - Purely combinational: (pattern, x, y[, frame_count]) -> pixel data.
  - Lets the same pattern function be reused by a future image checker.
- The control FSM and counters stay in image_generator.

Test Plan (Width=4, Height=3, 8-bit data):
- Request pulse high for 1 cycle, pattern=1, ready=1 -> valid on the next edge; 12 pixels with data 0,1,2,3 repeated; start on pixel 0; stop on pixel 11; then valid=0 and busy=0.
- Request held high, pattern=3 -> two frames back-to-back with no valid gap; second-frame start follows the first stop immediately; data row y=1 is 1,0,3,2.
- Ready toggled 1 cycle on / 3 cycles off throughout a frame, pattern=2 -> every pixel is held stable while stalled; sequence 0,0,0,0,1,1,1,1,2,2,2,2; no pixel lost or duplicated.
- Cancel for 1 cycle after pixel 5 is accepted -> valid=0 next cycle, busy=0; a new request restarts at (0,0) with start=1; with IMAGE_GENERATOR_FRAME_COUNT_EN, frame_count is unchanged.
- Reset asserted asynchronously mid-frame (between clock edges) -> valid/start/stop/data/busy go to 0 without waiting for an edge; the next request yields a full frame from (0,0).
- Request and cancel both high in Idle -> no frame; error stays 0 throughout all tests; with the macro, frame_count reads 2 after two completed frames.
